sid_dac_serializer: RTL and testbench

- Downstream output stage of the SID core. Takes one stereo pair of parallel audio samples per frame from the voice mixer and shifts both out MSB-first on two serial data lines.
- The two lines share one bit clock and one latch-enable.
- Drives the DAC_clk, DAC_dat_1, DAC_dat_2 and DAC_le pins of the SID macro directly. The external dual serial DAC latches on the DAC_le pulse.

---
 rtl/sid_dac_serializer.sv | 124 ++++++++++++
 tb/tb_sid_dac_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sid_dac_serializer.sv
// Stereo parallel-to-serial output stage for the SID core: shifts two samples out
// MSB-first in lockstep on a shared bit clock, then pulses the DAC latch enable.
module sid_dac_serializer #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_1,
    input  logic [DATA_W-1:0] sample_2,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              DAC_clk,
    output logic              DAC_dat_1,
    output logic              DAC_dat_2,
    output logic              DAC_le,
    output logic              underrun
);

    localparam int PH_W  = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HI   = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]  LE_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t             r_state, w_next;
    logic [PH_W-1:0]    r_phase, w_phase;
    logic [BIT_W-1:0]   r_bit, w_bit;
    logic [DATA_W-1:0]  r_sh1, r_sh2, w_sh1, w_sh2;
    logic               r_ready, r_dclk, r_dat1, r_dat2, r_le, r_uf, r_first_idle;
    logic               w_capture;

    assign w_capture = (r_state == IDLE) && sample_valid && r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_phase = r_phase;
        w_bit   = r_bit;
        w_sh1   = r_sh1;
        w_sh2   = r_sh2;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_next  = SHIFT;
                    w_phase = '0;
                    w_bit   = BIT_TOP;
                    w_sh1   = sample_1;
                    w_sh2   = sample_2;
                end
            end
            SHIFT: begin
                // Advance to the next bit only on the high-to-low edge of DAC_clk.
                if (r_phase == PH_LAST) begin
                    w_phase = '0;
                    if (r_bit == '0) begin
                        w_next = LATCH;
                    end else begin
                        w_bit = r_bit - BIT_W'(1);
                        w_sh1 = {r_sh1[DATA_W-2:0], 1'b0};
                        w_sh2 = {r_sh2[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    w_phase = r_phase + PH_W'(1);
                end
            end
            LATCH: begin
                if (r_phase == LE_LAST) begin
                    w_next  = IDLE;
                    w_phase = '0;
                end else begin
                    w_phase = r_phase + PH_W'(1);
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Pins are registered from next-state values so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase      <= '0;
            r_bit        <= '0;
            r_sh1        <= '0;
            r_sh2        <= '0;
            r_ready      <= 1'b0;
            r_dclk       <= 1'b0;
            r_dat1       <= 1'b0;
            r_dat2       <= 1'b0;
            r_le         <= 1'b0;
            r_uf         <= 1'b0;
            r_first_idle <= 1'b0;
        end else begin
            r_phase      <= w_phase;
            r_bit        <= w_bit;
            r_sh1        <= w_sh1;
            r_sh2        <= w_sh2;
            r_ready      <= (w_next == IDLE);
            r_dclk       <= (w_next == SHIFT) && (w_phase >= PH_HI);
            r_dat1       <= (w_next == SHIFT) && w_sh1[DATA_W-1];
            r_dat2       <= (w_next == SHIFT) && w_sh2[DATA_W-1];
            r_le         <= (w_next == LATCH);
            r_first_idle <= (r_state == LATCH) && (w_next == IDLE);
            // Flags a frame boundary that passed without a fresh pair waiting.
            r_uf         <= r_first_idle && !sample_valid;
        end
    end

    assign sample_ready = r_ready;
    assign DAC_clk      = r_dclk;
    assign DAC_dat_1    = r_dat1;
    assign DAC_dat_2    = r_dat2;
    assign DAC_le       = r_le;
    assign underrun     = r_uf;

endmodule

// File: tb/tb_sid_dac_serializer.sv
// Directed bench for sid_dac_serializer: default instance plus a 12-bit, CLK_DIV=1 instance.
module tb_sid_dac_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_s1 = '0, a_s2 = '0;
    logic        a_valid = 1'b0;
    logic        a_ready, a_clk, a_d1, a_d2, a_le, a_uf;
    logic [11:0] b_s1 = '0, b_s2 = '0;
    logic        b_valid = 1'b0;
    logic        b_ready, b_clk, b_d1, b_d2, b_le, b_uf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sid_dac_serializer u_a (
        .clk(clk), .rst(rst), .sample_1(a_s1), .sample_2(a_s2), .sample_valid(a_valid),
        .sample_ready(a_ready), .DAC_clk(a_clk), .DAC_dat_1(a_d1), .DAC_dat_2(a_d2),
        .DAC_le(a_le), .underrun(a_uf)
    );

    sid_dac_serializer #(.DATA_W(12), .CLK_DIV(1)) u_b (
        .clk(clk), .rst(rst), .sample_1(b_s1), .sample_2(b_s2), .sample_valid(b_valid),
        .sample_ready(b_ready), .DAC_clk(b_clk), .DAC_dat_1(b_d1), .DAC_dat_2(b_d2),
        .DAC_le(b_le), .underrun(b_uf)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int a_outs();
        return int'({a_ready, a_clk, a_d1, a_d2, a_le, a_uf});
    endfunction

    function automatic int b_outs();
        return int'({b_ready, b_clk, b_d1, b_d2, b_le, b_uf});
    endfunction

    // Called while the capturing edge is pending; returns at the first cycle with ready high.
    // rdy is the number of clk edges from capture to ready (-1 on timeout).
    task automatic collect(input bit sel, input int div, input bit wiggle,
                           output int d1, output int d2, output int edges, output int hi,
                           output int le, output int rdy, output int glitch,
                           output int badp, output int uf);
        logic c, x1, x2, pc, p1, p2, r, l, u;
        int   last;
        bit   done;
        d1 = 0; d2 = 0; edges = 0; hi = 0; le = 0; rdy = -1; glitch = 0; badp = 0; uf = 0;
        pc = 1'b0; p1 = 1'b0; p2 = 1'b0; last = 0; done = 1'b0;
        for (int k = 1; k <= 200 && !done; k++) begin
            @(negedge clk);
            c  = sel ? b_clk : a_clk;
            x1 = sel ? b_d1 : a_d1;
            x2 = sel ? b_d2 : a_d2;
            r  = sel ? b_ready : a_ready;
            l  = sel ? b_le : a_le;
            u  = sel ? b_uf : a_uf;
            if (c && !pc) begin
                if (edges > 0 && (k - last) != 2 * div) badp++;
                last = k;
                edges++;
                d1 = (d1 << 1) | int'(x1);
                d2 = (d2 << 1) | int'(x2);
            end
            if (k > 1 && (x1 !== p1 || x2 !== p2) && !(pc && !c)) glitch++;
            if (c) hi++;
            if (l) le++;
            if (u) uf++;
            if (r) begin
                rdy  = k - 1;
                done = 1'b1;
            end
            pc = c; p1 = x1; p2 = x2;
            if (wiggle) begin
                a_s1    = 16'($urandom);
                a_valid = (k < 40) ? k[0] : 1'b0;
            end
        end
    endtask

    initial begin
        int d1, d2, ed, hi, le, rdy, gl, bp, uf, re, sle;
        logic p;

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_outs_a", a_outs(), 0);
        end
        chk("rst_outs_b", b_outs(), 0);
        rst = 1'b0;
        #1 chk("ready_before_edge", int'(a_ready), 0);
        @(negedge clk);
        chk("ready_after_rel_a", int'(a_ready), 1);
        chk("ready_after_rel_b", int'(b_ready), 1);
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_clk || b_clk) hi++;
        end
        chk("idle_no_dclk", hi, 0);

        // Single frame, defaults
        a_s1 = 16'hA5C3; a_s2 = 16'h0F0F; a_valid = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0;
        collect(1'b0, 2, 1'b0, d1, d2, ed, hi, le, rdy, gl, bp, uf);
        chk("f1_dat1", d1, 32'hA5C3);
        chk("f1_dat2", d2, 32'h0F0F);
        chk("f1_edges", ed, 16);
        chk("f1_hi_cycles", hi, 32);
        chk("f1_period", bp, 0);
        chk("f1_setup_hold", gl, 0);
        chk("f1_le_cycles", le, 2);
        chk("f1_ready_edge", rdy, 66);
        chk("f1_uf_in_frame", uf, 0);
        @(negedge clk);
        chk("f1_underrun", int'(a_uf), 1);
        @(negedge clk);
        chk("f1_underrun_1cyc", int'(a_uf), 0);
        chk("f1_stay_idle", int'(a_ready), 1);

        // Back-to-back with valid held high
        a_s1 = 16'h0001; a_s2 = 16'hFFFF; a_valid = 1'b1;
        @(posedge clk); #1 begin a_s1 = 16'h8000; a_s2 = 16'h7FFF; end
        collect(1'b0, 2, 1'b0, d1, d2, ed, hi, le, rdy, gl, bp, uf);
        chk("b2b1_dat1", d1, 32'h0001);
        chk("b2b1_dat2", d2, 32'hFFFF);
        chk("b2b1_ready_edge", rdy, 66);
        collect(1'b0, 2, 1'b0, d1, d2, ed, hi, le, rdy, gl, bp, uf);
        a_valid = 1'b0;
        chk("b2b2_dat1", d1, 32'h8000);
        chk("b2b2_dat2", d2, 32'h7FFF);
        chk("b2b2_ready_edge", rdy, 66);
        chk("b2b2_edges", ed, 16);
        chk("b2b_no_underrun", uf, 0);
        @(negedge clk);
        chk("b2b_tail_underrun", int'(a_uf), 1);

        // Parameter sweep instance
        b_s1 = 12'h800; b_s2 = 12'h3A5; b_valid = 1'b1;
        @(posedge clk); #1 b_valid = 1'b0;
        collect(1'b1, 1, 1'b0, d1, d2, ed, hi, le, rdy, gl, bp, uf);
        chk("p_dat1", d1, 32'h800);
        chk("p_dat2", d2, 32'h3A5);
        chk("p_edges", ed, 12);
        chk("p_period", bp, 0);
        chk("p_le_cycles", le, 1);
        chk("p_ready_edge", rdy, 25);

        // Reset mid-frame
        @(negedge clk);
        a_s1 = 16'hAAAA; a_s2 = 16'h5555; a_valid = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0;
        re = 0; sle = 0; p = 1'b0;
        for (int k = 0; k < 200 && re < 5; k++) begin
            @(negedge clk);
            if (a_clk && !p) re++;
            p = a_clk;
            if (a_le) sle++;
        end
        chk("mid_edges", re, 5);
        rst = 1'b1;
        #1 chk("mid_async_zero", a_outs(), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (a_le) sle++;
            chk("mid_hold_zero", a_outs(), 0);
        end
        chk("mid_no_le", sle, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready_back", int'(a_ready), 1);
        a_s1 = 16'h1234; a_s2 = 16'h4321; a_valid = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0;
        collect(1'b0, 2, 1'b0, d1, d2, ed, hi, le, rdy, gl, bp, uf);
        chk("mid_new_dat1", d1, 32'h1234);
        chk("mid_new_dat2", d2, 32'h4321);
        chk("mid_new_ready", rdy, 66);

        // Inputs ignored while shifting
        @(negedge clk);
        a_s1 = 16'h5A3C; a_s2 = 16'hC3A5; a_valid = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0;
        collect(1'b0, 2, 1'b1, d1, d2, ed, hi, le, rdy, gl, bp, uf);
        chk("ign_dat1", d1, 32'h5A3C);
        chk("ign_dat2", d2, 32'hC3A5);
        chk("ign_ready_edge", rdy, 66);
        @(negedge clk);
        chk("ign_no_extra_capture", int'(a_ready), 1);
        chk("ign_dclk_idle", int'(a_clk), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
